// File: rtl/cfg_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : cfg_chain_loader
// Brief    : Daisy-chained serial configuration loader. Forwards the stream
//            downstream with one cycle of latency and atomically commits the
//            payload of frames addressed to this tile (or broadcast) to cfg.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_chain_loader #(
    parameter int CFG_SIZE = 256,
    parameter int ID_WIDTH = 3,
    parameter int ID       = 7
) (
    input  logic                clk,
    input  logic                crst_n,
    input  logic                cfg_in_start,
    input  logic                cfg_bit_in,
    output logic                cfg_out_start,
    output logic                cfg_bit_out,
    output logic [CFG_SIZE-1:0] cfg,
    output logic                cfg_busy,
    output logic                cfg_done
);

    localparam int c_CNT_W = $clog2(((ID_WIDTH > CFG_SIZE) ? ID_WIDTH : CFG_SIZE) + 1);

    localparam logic [c_CNT_W-1:0]  c_CNT_HDR     = c_CNT_W'(ID_WIDTH - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_PAYLOAD = c_CNT_W'(CFG_SIZE);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [ID_WIDTH-1:0] c_ID          = ID_WIDTH'(ID);
    localparam logic [ID_WIDTH-1:0] c_BCAST       = {ID_WIDTH{1'b1}};

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_HDR  = 2'd1;
    localparam logic [1:0] c_LOAD = 2'd2;
    localparam logic [1:0] c_SKIP = 2'd3;

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [ID_WIDTH-1:0] r_hdr;
    logic [CFG_SIZE-1:0] r_shadow;
    logic [CFG_SIZE-1:0] r_cfg;
    logic                r_done;
    logic                r_out_start;
    logic                r_bit_out;

    logic [1:0]          w_state_next;
    logic [c_CNT_W-1:0]  w_cnt_next;
    logic [ID_WIDTH-1:0] w_hdr_next;
    logic [CFG_SIZE-1:0] w_shadow_next;
    logic                w_commit;
    logic [ID_WIDTH-1:0] w_hdr_first;
    logic [ID_WIDTH-1:0] w_hdr_shift;
    logic [CFG_SIZE-1:0] w_shadow_shift;
    logic                w_match_first;
    logic                w_match_shift;

    always_comb begin
        w_hdr_first    = ID_WIDTH'(cfg_bit_in);
        w_hdr_shift    = (r_hdr << 1) | ID_WIDTH'(cfg_bit_in);
        w_shadow_shift = (r_shadow << 1) | CFG_SIZE'(cfg_bit_in);
        w_match_first  = (w_hdr_first == c_ID) || (w_hdr_first == c_BCAST);
        w_match_shift  = (w_hdr_shift == c_ID) || (w_hdr_shift == c_BCAST);
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_hdr_next    = r_hdr;
        w_shadow_next = r_shadow;
        w_commit      = 1'b0;

        // A start strobe always wins: it aborts any frame in flight, even on
        // its final payload bit, and begins a new header with this bit.
        if (cfg_in_start) begin
            w_hdr_next = w_hdr_first;
            if (ID_WIDTH == 1) begin
                w_cnt_next   = c_CNT_PAYLOAD;
                w_state_next = w_match_first ? c_LOAD : c_SKIP;
            end else begin
                w_cnt_next   = c_CNT_HDR;
                w_state_next = c_HDR;
            end
        end else begin
            case (r_state)
                c_HDR: begin
                    w_hdr_next = w_hdr_shift;
                    if (r_cnt == c_CNT_ONE) begin
                        w_cnt_next   = c_CNT_PAYLOAD;
                        w_state_next = w_match_shift ? c_LOAD : c_SKIP;
                    end else begin
                        w_cnt_next = r_cnt - c_CNT_ONE;
                    end
                end
                c_LOAD: begin
                    w_shadow_next = w_shadow_shift;
                    w_cnt_next    = r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        w_commit     = 1'b1;
                        w_state_next = c_IDLE;
                    end
                end
                c_SKIP: begin
                    w_cnt_next = r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        w_state_next = c_IDLE;
                    end
                end
                default: begin
                    w_state_next = c_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge crst_n) begin
        if (!crst_n) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_hdr       <= '0;
            r_shadow    <= '0;
            r_cfg       <= '0;
            r_done      <= 1'b0;
            r_out_start <= 1'b0;
            r_bit_out   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_hdr       <= w_hdr_next;
            r_shadow    <= w_shadow_next;
            r_done      <= w_commit;
            r_out_start <= cfg_in_start;
            r_bit_out   <= cfg_bit_in;
            if (w_commit) begin
                r_cfg <= w_shadow_shift;
            end
        end
    end

    assign cfg           = r_cfg;
    assign cfg_done      = r_done;
    assign cfg_out_start = r_out_start;
    assign cfg_bit_out   = r_bit_out;
    assign cfg_busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cfg_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfg_chain_loader
// Brief    : Directed self-checking bench for cfg_chain_loader (8-bit payload,
//            3-bit header, tile ID 5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfg_chain_loader;

    localparam int c_CFG_SIZE = 8;
    localparam int c_ID_WIDTH = 3;
    localparam int c_ID       = 5;

    logic                  clk;
    logic                  crst_n;
    logic                  cfg_in_start;
    logic                  cfg_bit_in;
    logic                  cfg_out_start;
    logic                  cfg_bit_out;
    logic [c_CFG_SIZE-1:0] cfg;
    logic                  cfg_busy;
    logic                  cfg_done;

    int checks;
    int errors;
    int cyc;
    int done_seen;
    int busy_seen;
    int last_done_cyc;
    int prev_done_cyc;

    cfg_chain_loader #(
        .CFG_SIZE (c_CFG_SIZE),
        .ID_WIDTH (c_ID_WIDTH),
        .ID       (c_ID)
    ) u_dut (
        .clk           (clk),
        .crst_n        (crst_n),
        .cfg_in_start  (cfg_in_start),
        .cfg_bit_in    (cfg_bit_in),
        .cfg_out_start (cfg_out_start),
        .cfg_bit_out   (cfg_bit_out),
        .cfg           (cfg),
        .cfg_busy      (cfg_busy),
        .cfg_done      (cfg_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Outputs settle after posedge; count them at the following negedge.
    always @(negedge clk) begin
        if (cfg_done === 1'b1) begin
            done_seen++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
        end
        if (cfg_busy === 1'b1) busy_seen++;
    end

    // Drive one stream bit just after a negedge; stimulus is sampled at the next posedge.
    task automatic tick(input logic s, input logic b);
        @(negedge clk);
        #1;
        cfg_in_start = s;
        cfg_bit_in   = b;
    endtask

    task automatic send_frame(input logic [2:0] h, input logic [7:0] p);
        tick(1'b1, h[2]);
        tick(1'b0, h[1]);
        tick(1'b0, h[0]);
        for (int i = 7; i >= 0; i--) tick(1'b0, p[i]);
    endtask

    task automatic test_reset();
        crst_n       = 1'b0;
        cfg_in_start = 1'b0;
        cfg_bit_in   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        crst_n = 1'b1;
        tick(1'b0, 1'b0);
        checks++;
        if (cfg !== 8'h00) begin errors++; $display("FAIL reset_cfg actual=%h expected=00", cfg); end
        checks++;
        if ({cfg_busy, cfg_done, cfg_out_start, cfg_bit_out} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags actual=%b expected=0000", {cfg_busy, cfg_done, cfg_out_start, cfg_bit_out});
        end
    endtask

    task automatic test_match_load();
        int d0, b0;
        d0 = done_seen;
        b0 = busy_seen;
        send_frame(3'b101, 8'b1011_0010);
        checks++;
        if (cfg !== 8'h00) begin errors++; $display("FAIL load_no_partial actual=%h expected=00", cfg); end
        tick(1'b0, 1'b0);
        checks++;
        if (cfg !== 8'hB2) begin errors++; $display("FAIL load_cfg actual=%h expected=b2", cfg); end
        checks++;
        if (cfg_done !== 1'b1) begin errors++; $display("FAIL load_done_high actual=%b expected=1", cfg_done); end
        tick(1'b0, 1'b0);
        checks++;
        if (cfg_done !== 1'b0) begin errors++; $display("FAIL load_done_low actual=%b expected=0", cfg_done); end
        tick(1'b0, 1'b0);
        checks++;
        if (done_seen - d0 !== 1) begin errors++; $display("FAIL load_done_count actual=%0d expected=1", done_seen - d0); end
        // Busy spans the registered states from the strobe edge to the commit edge.
        checks++;
        if (busy_seen - b0 !== 10) begin errors++; $display("FAIL load_busy_cycles actual=%0d expected=10", busy_seen - b0); end
    endtask

    task automatic test_forward_skip();
        logic [10:0] bits;
        logic        prev_s, prev_b;
        int          d0, bad;
        bits   = {3'b011, 8'hFF};
        d0     = done_seen;
        bad    = 0;
        prev_s = 1'b0;
        prev_b = 1'b0;
        for (int i = 10; i >= -1; i--) begin
            @(negedge clk);
            #1;
            if (cfg_out_start !== prev_s || cfg_bit_out !== prev_b) bad++;
            prev_s       = (i == 10);
            prev_b       = (i >= 0) ? bits[i] : 1'b0;
            cfg_in_start = prev_s;
            cfg_bit_in   = prev_b;
        end
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL forward_delay actual=%0d expected=0 mismatching cycles", bad); end
        checks++;
        if (cfg !== 8'hB2) begin errors++; $display("FAIL skip_cfg_hold actual=%h expected=b2", cfg); end
        checks++;
        if (done_seen - d0 !== 0) begin errors++; $display("FAIL skip_no_done actual=%0d expected=0", done_seen - d0); end
    endtask

    task automatic test_broadcast();
        int d0;
        d0 = done_seen;
        send_frame(3'b111, 8'h3C);
        tick(1'b0, 1'b0);
        checks++;
        if (cfg !== 8'h3C) begin errors++; $display("FAIL bcast_cfg actual=%h expected=3c", cfg); end
        tick(1'b0, 1'b0);
        checks++;
        if (done_seen - d0 !== 1) begin errors++; $display("FAIL bcast_done actual=%0d expected=1", done_seen - d0); end
    endtask

    task automatic test_abort();
        int d0, bad;
        d0  = done_seen;
        bad = 0;
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        if (cfg !== 8'h3C) bad++;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            tick(1'b0, i[0] ? 1'b0 : 1'b0);
            cfg_bit_in = (i == 7 || i == 0);
            if (cfg !== 8'h3C) bad++;
        end
        tick(1'b0, 1'b0);
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL abort_no_partial actual=%0d expected=0 early cfg changes", bad); end
        checks++;
        if (cfg !== 8'h81) begin errors++; $display("FAIL abort_cfg actual=%h expected=81", cfg); end
        tick(1'b0, 1'b0);
        checks++;
        if (done_seen - d0 !== 1) begin errors++; $display("FAIL abort_done_count actual=%0d expected=1", done_seen - d0); end
    endtask

    task automatic test_async_reset();
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
        @(posedge clk);
        #2;
        crst_n = 1'b0;
        #1;
        checks++;
        if (cfg !== 8'h00) begin errors++; $display("FAIL areset_cfg actual=%h expected=00", cfg); end
        checks++;
        if ({cfg_busy, cfg_out_start, cfg_bit_out} !== 3'b000) begin
            errors++;
            $display("FAIL areset_flags actual=%b expected=000", {cfg_busy, cfg_out_start, cfg_bit_out});
        end
        #1;
        crst_n = 1'b1;
        send_frame(3'b101, 8'h5A);
        tick(1'b0, 1'b0);
        checks++;
        if (cfg !== 8'h5A) begin errors++; $display("FAIL areset_reload actual=%h expected=5a", cfg); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] p;
        int         d0;
        d0 = done_seen;
        send_frame(3'b101, 8'hF0);
        tick(1'b1, 1'b1);
        checks++;
        if (cfg !== 8'hF0) begin errors++; $display("FAIL b2b_first_cfg actual=%h expected=f0", cfg); end
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        p = 8'h0F;
        for (int i = 7; i >= 0; i--) tick(1'b0, p[i]);
        tick(1'b0, 1'b0);
        checks++;
        if (cfg !== 8'h0F) begin errors++; $display("FAIL b2b_second_cfg actual=%h expected=0f", cfg); end
        tick(1'b0, 1'b0);
        checks++;
        if (done_seen - d0 !== 2) begin errors++; $display("FAIL b2b_done_count actual=%0d expected=2", done_seen - d0); end
        checks++;
        if (last_done_cyc - prev_done_cyc !== 11) begin
            errors++;
            $display("FAIL b2b_done_spacing actual=%0d expected=11", last_done_cyc - prev_done_cyc);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        done_seen     = 0;
        busy_seen     = 0;
        last_done_cyc = 0;
        prev_done_cyc = 0;
        test_reset();
        test_match_load();
        test_forward_skip();
        test_broadcast();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
